// File: rtl/bf_tape_controller.sv
// ---------------------------------------------------------------------------------------------
// bf_tape_controller
//
// Purpose:
//   Owns the Brainfuck data tape. Holds the data pointer, turns the core's tape ops into
//   read-modify-write sequences that respect the RAM's two-edge write-to-read latency, and
//   arbitrates the tape between the core and a host/debug port.
//
// Parameters:
//   addrSize    - tape address width (pointer wraps modulo 2**addrSize)
//   contentSize - cell width
//
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   cmd_valid/cmd_ready        - core command handshake
//   cmd_op, cmd_data           - op code (0 NOP,1 >,2 <,3 +,4 -,5 load,6 read,7 NOP), load value
//   rsp_valid/rsp_ready        - CELL_READ response handshake
//   rsp_data                   - cell value returned by CELL_READ
//   zero_flag                  - current cell is zero (meaningful while cmd_ready=1)
//   ptr                        - current data pointer
//   ptr_err                    - sticky pointer bounds error (tied 0 unless bounds checking on)
//   host_req/host_we/host_gnt  - host access request, direction, grant
//   host_addr, host_wdata      - host address and write data
//   host_rdata_valid           - one-cycle pulse qualifying host_rdata
//   host_rdata                 - host read data
//   ram_addr_in/ram_data_in    - RAM write address / data
//   ram_write_rq               - RAM write strobe
//   ram_addr_out/ram_data_out  - RAM read address / combinational read data
//
// Configuration:
//   BF_TAPE_BOUNDS_EN - when defined, PTR_INC at the top address and PTR_DEC at 0 leave the
//                       pointer unchanged and set the sticky ptr_err flag. When undefined the
//                       pointer wraps and ptr_err is tied to 0.
// ---------------------------------------------------------------------------------------------
module bf_tape_controller #(
    parameter int unsigned addrSize    = 9,
    parameter int unsigned contentSize = 8
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [2:0]             cmd_op,
    input  logic [contentSize-1:0] cmd_data,

    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [contentSize-1:0] rsp_data,

    output logic                   zero_flag,
    output logic [addrSize-1:0]    ptr,
    output logic                   ptr_err,

    input  logic                   host_req,
    input  logic                   host_we,
    input  logic [addrSize-1:0]    host_addr,
    input  logic [contentSize-1:0] host_wdata,
    output logic                   host_gnt,
    output logic                   host_rdata_valid,
    output logic [contentSize-1:0] host_rdata,

    output logic [addrSize-1:0]    ram_addr_in,
    output logic [contentSize-1:0] ram_data_in,
    output logic                   ram_write_rq,
    output logic [addrSize-1:0]    ram_addr_out,
    input  logic [contentSize-1:0] ram_data_out
);

    localparam logic [2:0] OpNop     = 3'd0;
    localparam logic [2:0] OpPtrInc  = 3'd1;
    localparam logic [2:0] OpPtrDec  = 3'd2;
    localparam logic [2:0] OpCellInc = 3'd3;
    localparam logic [2:0] OpCellDec = 3'd4;
    localparam logic [2:0] OpCellLd  = 3'd5;
    localparam logic [2:0] OpCellRd  = 3'd6;

    typedef enum logic [2:0] {
        StIdle,
        StModify,
        StSettle,
        StResp,
        StHread
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;

    logic [addrSize-1:0]      r_ptr;
    // 1 = host won the last arbitration; reset value makes the core win the first conflict.
    logic                     r_last_host;
    // Shared by core/host writes (write address) and host reads (read address in StHread).
    logic [addrSize-1:0]      r_addr;
    logic [contentSize-1:0]   r_wdata;
    logic [contentSize-1:0]   r_rsp_data;
    logic [contentSize-1:0]   r_host_rdata;
    logic                     r_host_rdata_valid;

    logic                     w_cmd_fire;
    logic                     w_host_fire;
    logic [addrSize-1:0]      w_ptr_next;
    logic                     w_ptr_oob;
    logic [contentSize-1:0]   w_cell_inc;
    logic [contentSize-1:0]   w_cell_dec;

    assign w_cmd_fire  = cmd_valid & cmd_ready;
    assign w_host_fire = host_gnt;
    assign w_cell_inc  = ram_data_out + contentSize'(1);
    assign w_cell_dec  = ram_data_out - contentSize'(1);

    // Pointer update for an accepted PTR_INC / PTR_DEC.
    always_comb begin
        w_ptr_next = r_ptr;
        w_ptr_oob  = 1'b0;
        if (w_cmd_fire) begin
            if (cmd_op == OpPtrInc) begin
`ifdef BF_TAPE_BOUNDS_EN
                if (&r_ptr) begin
                    w_ptr_oob = 1'b1;
                end else begin
                    w_ptr_next = r_ptr + addrSize'(1);
                end
`else
                w_ptr_next = r_ptr + addrSize'(1);
`endif
            end else if (cmd_op == OpPtrDec) begin
`ifdef BF_TAPE_BOUNDS_EN
                if (r_ptr == '0) begin
                    w_ptr_oob = 1'b1;
                end else begin
                    w_ptr_next = r_ptr - addrSize'(1);
                end
`else
                w_ptr_next = r_ptr - addrSize'(1);
`endif
            end
        end
    end

    // -----------------------------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -----------------------------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_cmd_fire) begin
                    case (cmd_op)
                        OpCellInc, OpCellDec, OpCellLd: w_state_next = StModify;
                        OpCellRd:                       w_state_next = StResp;
                        default:                        w_state_next = StIdle;
                    endcase
                end else if (w_host_fire) begin
                    w_state_next = host_we ? StModify : StHread;
                end
            end
            StModify: w_state_next = StSettle;
            // Lets the write reach the read side before the next op samples the cell.
            StSettle: w_state_next = StIdle;
            StResp:   w_state_next = rsp_ready ? StIdle : StResp;
            StHread:  w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    // -----------------------------------------------------------------------------------------
    // FSM: outputs
    // -----------------------------------------------------------------------------------------
    always_comb begin
        cmd_ready    = 1'b0;
        host_gnt     = 1'b0;
        ram_write_rq = 1'b0;
        rsp_valid    = 1'b0;
        ram_addr_out = r_ptr;
        unique case (r_state)
            StIdle: begin
                // Exactly one side can win per cycle; on conflict the loser of the last
                // arbitration goes first.
                cmd_ready = !host_req || r_last_host;
                host_gnt  = host_req && (!cmd_valid || !r_last_host);
            end
            StModify: ram_write_rq = !reset;
            StSettle: ;
            StResp:   rsp_valid = 1'b1;
            StHread:  ram_addr_out = r_addr;
            default:  ;
        endcase
    end

    // -----------------------------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr              <= '0;
            r_last_host        <= 1'b1;
            r_addr             <= '0;
            r_wdata            <= '0;
            r_rsp_data         <= '0;
            r_host_rdata       <= '0;
            r_host_rdata_valid <= 1'b0;
        end else begin
            r_ptr              <= w_ptr_next;
            r_host_rdata_valid <= (r_state == StHread);
            if (r_state == StHread) begin
                r_host_rdata <= ram_data_out;
            end
            if (w_cmd_fire) begin
                r_last_host <= 1'b0;
                r_addr      <= r_ptr;
                case (cmd_op)
                    OpCellInc: r_wdata    <= w_cell_inc;
                    OpCellDec: r_wdata    <= w_cell_dec;
                    OpCellLd:  r_wdata    <= cmd_data;
                    OpCellRd:  r_rsp_data <= ram_data_out;
                    default:   ;
                endcase
            end else if (w_host_fire) begin
                r_last_host <= 1'b1;
                r_addr      <= host_addr;
                r_wdata     <= host_wdata;
            end
        end
    end

`ifdef BF_TAPE_BOUNDS_EN
    logic r_ptr_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr_err <= 1'b0;
        end else if (w_ptr_oob) begin
            r_ptr_err <= 1'b1;
        end
    end

    assign ptr_err = r_ptr_err;
`else
    logic w_unused_oob;
    assign w_unused_oob = w_ptr_oob;
    assign ptr_err      = 1'b0;
`endif

    assign ptr              = r_ptr;
    assign zero_flag        = (ram_data_out == '0);
    assign rsp_data         = r_rsp_data;
    assign host_rdata       = r_host_rdata;
    assign host_rdata_valid = r_host_rdata_valid;
    assign ram_addr_in      = r_addr;
    assign ram_data_in      = r_wdata;

    logic w_unused_nop;
    assign w_unused_nop = (cmd_op == OpNop);

endmodule

// File: tb/tb_bf_tape_controller.sv
module tb_bf_tape_controller;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       zero_flag;
    logic [8:0] ptr;
    logic       ptr_err;
    logic       host_req;
    logic       host_we;
    logic [8:0] host_addr;
    logic [7:0] host_wdata;
    logic       host_gnt;
    logic       host_rdata_valid;
    logic [7:0] host_rdata;
    logic [8:0] ram_addr_in;
    logic [7:0] ram_data_in;
    logic       ram_write_rq;
    logic [8:0] ram_addr_out;
    logic [7:0] ram_data_out;

    int checks;
    int errors;

    bf_tape_controller #(
        .addrSize   (9),
        .contentSize(8)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_op          (cmd_op),
        .cmd_data        (cmd_data),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_data        (rsp_data),
        .zero_flag       (zero_flag),
        .ptr             (ptr),
        .ptr_err         (ptr_err),
        .host_req        (host_req),
        .host_we         (host_we),
        .host_addr       (host_addr),
        .host_wdata      (host_wdata),
        .host_gnt        (host_gnt),
        .host_rdata_valid(host_rdata_valid),
        .host_rdata      (host_rdata),
        .ram_addr_in     (ram_addr_in),
        .ram_data_in     (ram_data_in),
        .ram_write_rq    (ram_write_rq),
        .ram_addr_out    (ram_addr_out),
        .ram_data_out    (ram_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tape RAM: write captured at one edge, committed at the next, so it is visible on the
    // combinational read side after the second edge.
    logic [7:0] mem [0:511];
    logic       mem_clr;
    logic       st_v;
    logic [8:0] st_a;
    logic [7:0] st_d;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 512; i++) mem[i] <= 8'h00;
            st_v <= 1'b0;
        end else begin
            if (st_v) mem[st_a] <= st_d;
            st_v <= ram_write_rq;
            st_a <= ram_addr_in;
            st_d <= ram_data_in;
        end
    end

    assign ram_data_out = mem[ram_addr_out];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
    endtask

    // Present a command, wait (bounded) for acceptance, return one tick after the accept edge.
    task automatic send_cmd(input logic [2:0] op, input logic [7:0] data);
        int waited;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        #1;
        waited = 0;
        while (cmd_ready !== 1'b1 && waited < 20) begin
            step();
            waited++;
        end
        checks++;
        if (waited >= 20) begin
            errors++;
            $display("FAIL cmd_accept_timeout: op %0d not accepted in 20 cycles", op);
        end
        step();
        cmd_valid = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (ptr !== 9'h000) begin errors++; $display("FAIL reset_ptr: got %h want 000", ptr); end
        checks++;
        if (rsp_valid !== 1'b0 || host_rdata_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valids: rsp_valid %b host_rdata_valid %b want 0 0",
                     rsp_valid, host_rdata_valid);
        end
        checks++;
        if (rsp_data !== 8'h00 || host_rdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_data: rsp_data %h host_rdata %h want 00 00", rsp_data, host_rdata);
        end
        checks++;
        if (cmd_ready !== 1'b1 || ram_write_rq !== 1'b0 || ptr_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: cmd_ready %b ram_write_rq %b ptr_err %b want 1 0 0",
                     cmd_ready, ram_write_rq, ptr_err);
        end
    endtask

    task automatic test_ptr_wrap();
        logic [8:0] exp_ptr;
        logic       exp_err;
        send_cmd(3'd2, 8'h00);
`ifdef BF_TAPE_BOUNDS_EN
        exp_ptr = 9'h000; exp_err = 1'b1;
`else
        exp_ptr = 9'h1FF; exp_err = 1'b0;
`endif
        checks++;
        if (ptr !== exp_ptr || ptr_err !== exp_err) begin
            errors++;
            $display("FAIL ptr_dec_at_zero: ptr %h err %b want %h %b", ptr, ptr_err, exp_ptr, exp_err);
        end
        send_cmd(3'd1, 8'h00);
`ifdef BF_TAPE_BOUNDS_EN
        exp_ptr = 9'h001; exp_err = 1'b1;
`else
        exp_ptr = 9'h000; exp_err = 1'b0;
`endif
        checks++;
        if (ptr !== exp_ptr || ptr_err !== exp_err) begin
            errors++;
            $display("FAIL ptr_inc_after: ptr %h err %b want %h %b", ptr, ptr_err, exp_ptr, exp_err);
        end
        do_reset();
        checks++;
        if (ptr_err !== 1'b0) begin errors++; $display("FAIL ptr_err_cleared: got %b want 0", ptr_err); end
        // Five PTR_INC back-to-back at one per cycle.
        cmd_valid = 1'b1;
        cmd_op    = 3'd1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (cmd_ready !== 1'b1) begin
                errors++;
                $display("FAIL ptr_b2b_ready: cycle %0d cmd_ready %b want 1", i, cmd_ready);
            end
            step();
        end
        cmd_valid = 1'b0;
        #1;
        checks++;
        if (ptr !== 9'h005) begin errors++; $display("FAIL ptr_b2b_value: got %h want 005", ptr); end
    endtask

    task automatic test_load_inc_read();
        send_cmd(3'd5, 8'hFF);
        checks++;
        if (ram_write_rq !== 1'b1 || ram_addr_in !== 9'h005 || ram_data_in !== 8'hFF ||
            cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL load_modify: wr %b addr %h data %h rdy %b want 1 005 ff 0",
                     ram_write_rq, ram_addr_in, ram_data_in, cmd_ready);
        end
        step();
        checks++;
        if (ram_write_rq !== 1'b0 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL load_settle: wr %b rdy %b want 0 0", ram_write_rq, cmd_ready);
        end
        step();
        checks++;
        if (cmd_ready !== 1'b1 || zero_flag !== 1'b0) begin
            errors++;
            $display("FAIL load_idle: rdy %b zero_flag %b want 1 0", cmd_ready, zero_flag);
        end
        send_cmd(3'd3, 8'h00);
        checks++;
        if (ram_write_rq !== 1'b1 || ram_data_in !== 8'h00 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL inc_wrap_modify: wr %b data %h rdy %b want 1 00 0",
                     ram_write_rq, ram_data_in, cmd_ready);
        end
        step();
        checks++;
        if (cmd_ready !== 1'b0) begin errors++; $display("FAIL inc_settle_ready: got %b want 0", cmd_ready); end
        step();
        checks++;
        if (cmd_ready !== 1'b1 || zero_flag !== 1'b1) begin
            errors++;
            $display("FAIL inc_zero_flag: rdy %b zero_flag %b want 1 1", cmd_ready, zero_flag);
        end
        send_cmd(3'd6, 8'h00);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 8'h00) begin
            errors++;
            $display("FAIL read_zero: rsp_valid %b rsp_data %h want 1 00", rsp_valid, rsp_data);
        end
        step();
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL read_done: rsp_valid %b rdy %b want 0 1", rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_back_to_back();
        send_cmd(3'd1, 8'h00);
        cmd_valid = 1'b1;
        cmd_op    = 3'd3;
        for (int k = 1; k <= 3; k++) begin
            step();
            checks++;
            if (ram_write_rq !== 1'b1 || ram_addr_in !== 9'h006 || ram_data_in !== 8'(k)) begin
                errors++;
                $display("FAIL b2b_inc_%0d: wr %b addr %h data %h want 1 006 %h",
                         k, ram_write_rq, ram_addr_in, ram_data_in, 8'(k));
            end
            step();
            step();
        end
        cmd_op = 3'd6;
        #1;
        step();
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== 8'h03 || cmd_ready !== 1'b0) begin
                errors++;
                $display("FAIL rsp_hold_%0d: valid %b data %h rdy %b want 1 03 0",
                         i, rsp_valid, rsp_data, cmd_ready);
            end
            step();
        end
        rsp_ready = 1'b1;
        step();
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL rsp_release: valid %b rdy %b want 0 1", rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_arbitration();
        logic [3:0] seq;
        int         n;
        do_reset();
        seq       = 4'b0000;
        n         = 0;
        host_we   = 1'b0;
        host_addr = 9'h005;
        host_req  = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = 3'd0;
        for (int c = 0; c < 12 && n < 4; c++) begin
            #1;
            checks++;
            if (cmd_valid && cmd_ready && host_gnt) begin
                errors++;
                $display("FAIL arb_exclusive: cycle %0d both accepted", c);
            end
            if (cmd_ready) begin
                seq[n] = 1'b0;
                n++;
            end else if (host_gnt) begin
                seq[n] = 1'b1;
                n++;
            end
            step();
        end
        host_req  = 1'b0;
        cmd_valid = 1'b0;
        checks++;
        if (n != 4 || seq !== 4'b1010) begin
            errors++;
            $display("FAIL arb_order: grants %0d seq %b want 4 1010 (core,host,core,host)", n, seq);
        end
        step();
    endtask

    task automatic test_host_write_read();
        host_req   = 1'b1;
        host_we    = 1'b1;
        host_addr  = 9'h010;
        host_wdata = 8'h42;
        #1;
        checks++;
        if (host_gnt !== 1'b1) begin errors++; $display("FAIL hwr_gnt: got %b want 1", host_gnt); end
        step();
        host_req = 1'b0;
        #1;
        checks++;
        if (ram_write_rq !== 1'b1 || ram_addr_in !== 9'h010 || ram_data_in !== 8'h42) begin
            errors++;
            $display("FAIL hwr_modify: wr %b addr %h data %h want 1 010 42",
                     ram_write_rq, ram_addr_in, ram_data_in);
        end
        step();
        step();
        host_req = 1'b1;
        host_we  = 1'b0;
        #1;
        checks++;
        if (host_gnt !== 1'b1) begin errors++; $display("FAIL hrd_gnt: got %b want 1", host_gnt); end
        step();
        host_req  = 1'b0;
        host_addr = 9'h033;
        #1;
        checks++;
        if (ram_addr_out !== 9'h010 || host_rdata_valid !== 1'b0) begin
            errors++;
            $display("FAIL hrd_addr: ram_addr_out %h valid %b want 010 0", ram_addr_out, host_rdata_valid);
        end
        step();
        checks++;
        if (host_rdata_valid !== 1'b1 || host_rdata !== 8'h42) begin
            errors++;
            $display("FAIL hrd_data: valid %b data %h want 1 42", host_rdata_valid, host_rdata);
        end
        step();
        checks++;
        if (host_rdata_valid !== 1'b0) begin
            errors++;
            $display("FAIL hrd_pulse: valid %b want 0", host_rdata_valid);
        end
    endtask

    task automatic test_reset_mid_op();
        send_cmd(3'd1, 8'h00);
        send_cmd(3'd1, 8'h00);
        host_req   = 1'b1;
        host_we    = 1'b1;
        host_addr  = 9'h020;
        host_wdata = 8'h99;
        #1;
        step();
        host_req = 1'b0;
        step();
        reset = 1'b1;
        #1;
        checks++;
        if (ram_write_rq !== 1'b0) begin errors++; $display("FAIL settle_reset_wr: got %b want 0", ram_write_rq); end
        step();
        reset = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b1 || ptr !== 9'h000 || ram_write_rq !== 1'b0) begin
            errors++;
            $display("FAIL settle_reset_idle: rdy %b ptr %h wr %b want 1 000 0",
                     cmd_ready, ptr, ram_write_rq);
        end
        // Reset during MODIFY must suppress the strobe so cell 0 stays zero.
        send_cmd(3'd5, 8'h77);
        checks++;
        if (ram_write_rq !== 1'b1) begin errors++; $display("FAIL modify_pre_reset: got %b want 1", ram_write_rq); end
        reset = 1'b1;
        #1;
        checks++;
        if (ram_write_rq !== 1'b0) begin errors++; $display("FAIL modify_reset_wr: got %b want 0", ram_write_rq); end
        step();
        reset = 1'b0;
        step();
        step();
        checks++;
        if (zero_flag !== 1'b1 || cmd_ready !== 1'b1 || host_rdata !== 8'h00) begin
            errors++;
            $display("FAIL modify_reset_nowrite: zero_flag %b rdy %b host_rdata %h want 1 1 00",
                     zero_flag, cmd_ready, host_rdata);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b1;
        mem_clr    = 1'b1;
        cmd_valid  = 1'b0;
        cmd_op     = 3'd0;
        cmd_data   = 8'h00;
        rsp_ready  = 1'b1;
        host_req   = 1'b0;
        host_we    = 1'b0;
        host_addr  = 9'h000;
        host_wdata = 8'h00;
        step();
        step();
        mem_clr = 1'b0;

        test_reset();
        test_ptr_wrap();
        test_load_inc_read();
        test_back_to_back();
        test_arbitration();
        test_host_write_read();
        test_reset_mid_op();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
